// File: rtl/store_commit_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_commit_buffer_pkg                                              |
// | Entry-state encoding and default widths for the store commit buffer. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package store_commit_buffer_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ALLOC = 2'd1,
    ST_RDY   = 2'd2,
    ST_CMT   = 2'd3
  } entry_state_e;

  localparam int c_def_depth  = 8;
  localparam int c_def_tag_w  = 5;
  localparam int c_def_addr_w = 10;
  localparam int c_def_data_w = 32;

  // Address and data are valid once an entry reaches RDY or CMT.
  function automatic logic is_resolved(input logic [1:0] st);
    return (st == ST_RDY) || (st == ST_CMT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scb_fwd_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scb_fwd_scan                                                         |
// | Youngest-first store-to-load forwarding search over occupied entries.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module scb_fwd_scan
  import store_commit_buffer_pkg::*;
#(
  parameter int DEPTH  = c_def_depth,
  parameter int ADDR_W = c_def_addr_w,
  parameter int DATA_W = c_def_data_w,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0][1:0]        state,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] data,
  input  logic [PTR_W-1:0]             tail,
  input  logic [CNT_W-1:0]             count,
  input  logic                         ld_v,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         fwd_hit,
  output logic [DATA_W-1:0]            fwd_data,
  output logic                         ld_block
);

  logic [PTR_W-1:0] w_idx;
  logic             w_done;

  // ALLOC entries younger than the hit (or any ALLOC when there is no hit)
  // are exactly those visited before the search stops.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    ld_block = 1'b0;
    w_done   = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = tail - PTR_W'(k + 1);
      if (ld_v && !w_done && (CNT_W'(k) < count)) begin
        if (is_resolved(state[w_idx]) && (addr[w_idx] == ld_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = data[w_idx];
          w_done   = 1'b1;
        end else if (state[w_idx] == ST_ALLOC) begin
          ld_block = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/store_commit_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_commit_buffer                                                  |
// | In-order store queue: allocate, resolve, commit, drain, forward.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter int DEPTH  = c_def_depth,
  parameter int TAG_W  = c_def_tag_w,
  parameter int ADDR_W = c_def_addr_w,
  parameter int DATA_W = c_def_data_w
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc,
  input  logic [TAG_W-1:0]  alloc_tag,
  output logic              full,
  input  logic              disp_v,
  input  logic [TAG_W-1:0]  disp_tag,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic [DATA_W-1:0] disp_data,
  input  logic              disp2_v,
  input  logic [TAG_W-1:0]  disp2_tag,
  input  logic [ADDR_W-1:0] disp2_addr,
  input  logic [DATA_W-1:0] disp2_data,
  input  logic              commit_sw,
  input  logic              commit_sw2,
  input  logic              mem_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              ld_v,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              ld_block
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  entry_state_e      r_state [DEPTH];
  logic [TAG_W-1:0]  r_tag   [DEPTH];
  logic [ADDR_W-1:0] r_addr  [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];

  logic [c_ptr_w-1:0] r_head, r_cpt, r_tail;
  logic [c_cnt_w-1:0] r_count;

  logic               w_alloc_ok;
  logic               w_cm0, w_cm1;
  logic [c_ptr_w-1:0] w_cpt1, w_cpt_nxt;
  logic [DEPTH-1:0]   w_d0_hit, w_d1_hit;

  logic [DEPTH-1:0][1:0]        w_st_flat;
  logic [DEPTH-1:0][ADDR_W-1:0] w_addr_flat;
  logic [DEPTH-1:0][DATA_W-1:0] w_data_flat;

  // full follows the registered count, so a same-cycle drain cannot admit an alloc.
  assign full       = (r_count == c_cnt_w'(DEPTH));
  assign w_alloc_ok = alloc && !full;

  // commit_sw2 alone is still a single commit.
  assign w_cm0     = commit_sw || commit_sw2;
  assign w_cm1     = commit_sw && commit_sw2;
  assign w_cpt1    = r_cpt + c_ptr_w'(1);
  assign w_cpt_nxt = w_cm1 ? (w_cpt1 + c_ptr_w'(1)) : (w_cm0 ? w_cpt1 : r_cpt);

  assign mem_we    = (r_state[r_head] == ST_CMT) && !mem_stall;
  assign mem_addr  = r_addr[r_head];
  assign mem_wdata = r_data[r_head];

  always_comb begin
    w_d0_hit    = '0;
    w_d1_hit    = '0;
    w_st_flat   = '0;
    w_addr_flat = '0;
    w_data_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_d0_hit[i]    = disp_v  && (r_state[i] == ST_ALLOC) && (r_tag[i] == disp_tag);
      w_d1_hit[i]    = disp2_v && (r_state[i] == ST_ALLOC) && (r_tag[i] == disp2_tag);
      w_st_flat[i]   = r_state[i];
      w_addr_flat[i] = r_addr[i];
      w_data_flat[i] = r_data[i];
    end
  end

  // Each entry is in exactly one state, so at most one branch can legally apply.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= ST_EMPTY;
        r_tag[i]   <= '0;
        r_addr[i]  <= '0;
        r_data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc_ok && (r_tail == c_ptr_w'(i))) begin
          r_state[i] <= ST_ALLOC;
          r_tag[i]   <= alloc_tag;
        end else if (w_d0_hit[i]) begin
          r_state[i] <= ST_RDY;
          r_addr[i]  <= disp_addr;
          r_data[i]  <= disp_data;
        end else if (w_d1_hit[i]) begin
          r_state[i] <= ST_RDY;
          r_addr[i]  <= disp2_addr;
          r_data[i]  <= disp2_data;
        end else if ((w_cm0 && (r_cpt == c_ptr_w'(i))) ||
                     (w_cm1 && (w_cpt1 == c_ptr_w'(i)))) begin
          r_state[i] <= ST_CMT;
        end else if (mem_we && (r_head == c_ptr_w'(i))) begin
          r_state[i] <= ST_EMPTY;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_cpt   <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_ptr_w'(mem_we);
      r_cpt   <= w_cpt_nxt;
      r_tail  <= r_tail + c_ptr_w'(w_alloc_ok);
      r_count <= r_count + c_cnt_w'(w_alloc_ok) - c_cnt_w'(mem_we);
    end
  end

  scb_fwd_scan #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  (c_ptr_w),
    .CNT_W  (c_cnt_w)
  ) u_fwd_scan (
    .state    (w_st_flat),
    .addr     (w_addr_flat),
    .data     (w_data_flat),
    .tail     (r_tail),
    .count    (r_count),
    .ld_v     (ld_v),
    .ld_addr  (ld_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .ld_block (ld_block)
  );

endmodule
`default_nettype wire

// File: tb/tb_store_commit_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_store_commit_buffer                                               |
// | Scoreboard bench: directed stores, commits, stalls, forwarding.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_store_commit_buffer;
  import store_commit_buffer_pkg::*;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 5;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              alloc = 1'b0;
  logic [TAG_W-1:0]  alloc_tag = '0;
  logic              full;
  logic              disp_v = 1'b0;
  logic [TAG_W-1:0]  disp_tag = '0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic [DATA_W-1:0] disp_data = '0;
  logic              disp2_v = 1'b0;
  logic [TAG_W-1:0]  disp2_tag = '0;
  logic [ADDR_W-1:0] disp2_addr = '0;
  logic [DATA_W-1:0] disp2_data = '0;
  logic              commit_sw = 1'b0;
  logic              commit_sw2 = 1'b0;
  logic              mem_stall = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              ld_v = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              ld_block;

  always #5 clk = ~clk;

  store_commit_buffer #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc(alloc), .alloc_tag(alloc_tag), .full(full),
    .disp_v(disp_v), .disp_tag(disp_tag), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp2_v(disp2_v), .disp2_tag(disp2_tag), .disp2_addr(disp2_addr), .disp2_data(disp2_data),
    .commit_sw(commit_sw), .commit_sw2(commit_sw2),
    .mem_stall(mem_stall), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ld_v(ld_v), .ld_addr(ld_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .ld_block(ld_block)
  );

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [TAG_W-1:0]         order_q[$];
  logic [ADDR_W-1:0]        m_addr [32];
  logic [DATA_W-1:0]        m_data [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Memory-write monitor, independent of the stimulus thread.
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] e;
    if (rst && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h required=no write",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          failures++;
          $display("FAIL mem_write: actual addr=0x%0h data=0x%0h required addr=0x%0h data=0x%0h",
                   mem_addr, mem_wdata, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // Committing a store that is not RDY is a protocol error on the bench side.
  always @(posedge clk) begin
    logic [2:0] idx1;
    if (rst && (commit_sw || commit_sw2)) begin
      assert (dut.r_state[dut.r_cpt] == ST_RDY) else $error("commit of non-ready entry");
      if (commit_sw && commit_sw2) begin
        idx1 = dut.r_cpt + 3'd1;
        assert (dut.r_state[idx1] == ST_RDY) else $error("second commit of non-ready entry");
      end
    end
  end

  task automatic set_alloc(input logic [TAG_W-1:0] tag, input bit accept);
    alloc = 1'b1;
    alloc_tag = tag;
    if (accept) order_q.push_back(tag);
  endtask

  task automatic set_disp0(input logic [TAG_W-1:0] tag, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input bit upd);
    disp_v = 1'b1; disp_tag = tag; disp_addr = a; disp_data = d;
    if (upd) begin m_addr[tag] = a; m_data[tag] = d; end
  endtask

  task automatic set_disp1(input logic [TAG_W-1:0] tag, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input bit upd);
    disp2_v = 1'b1; disp2_tag = tag; disp2_addr = a; disp2_data = d;
    if (upd) begin m_addr[tag] = a; m_data[tag] = d; end
  endtask

  task automatic set_commit(input int n);
    logic [TAG_W-1:0] t;
    commit_sw = 1'b1;
    t = order_q.pop_front();
    exp_q.push_back({m_addr[t], m_data[t]});
    if (n == 2) begin
      commit_sw2 = 1'b1;
      t = order_q.pop_front();
      exp_q.push_back({m_addr[t], m_data[t]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    alloc = 1'b0; disp_v = 1'b0; disp2_v = 1'b0;
    commit_sw = 1'b0; commit_sw2 = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      step();
      k++;
    end
    chk("drain_done_pending", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [TAG_W-1:0] t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      chk("idle_full", full, 0);
      chk("idle_mem_we", mem_we, 0);
      step();
    end
    chk("idle_mem_addr", mem_addr, 0);
    chk("idle_mem_wdata", mem_wdata, 0);
    chk("idle_fwd_hit", fwd_hit, 0);
    chk("idle_fwd_data", fwd_data, 0);
    chk("idle_ld_block", ld_block, 0);
    ld_v = 1'b1; ld_addr = '0; #1;
    chk("idle_ld_hit", fwd_hit, 0);
    chk("idle_ld_block_v", ld_block, 0);
    ld_v = 1'b0;

    // Single store, minimum commit-to-write latency
    set_alloc(5'd3, 1); step();
    set_disp0(5'd3, 10'h10, 32'hAA, 1); step();
    set_commit(1); step();
    chk("single_we", mem_we, 1);
    chk("single_addr", mem_addr, 32'h10);
    chk("single_data", mem_wdata, 32'hAA);
    step();
    chk("single_empty_we", mem_we, 0);

    // Fill, overflow attempt, paired commits
    for (int i = 0; i < 8; i++) begin
      set_alloc(5'(i), 1); step();
    end
    chk("fill_full", full, 1);
    set_alloc(5'd8, 0); step();
    chk("fill_full_after_extra", full, 1);
    for (int i = 0; i < 8; i += 2) begin
      set_disp0(5'(i), 10'(10'h40 + i), 32'h1000_0000 + i, 1);
      set_disp1(5'(i + 1), 10'(10'h40 + i + 1), 32'h1000_0000 + i + 1, 1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      set_commit(2); step();
    end
    wait_drain(20);
    chk("fill_full_after_drain", full, 0);
    ld_v = 1'b1; ld_addr = 10'h3FF; #1;
    chk("fill_no_stray_alloc", ld_block, 0);
    ld_v = 1'b0;

    // Memory stall with committed head
    set_alloc(5'd10, 1); step();
    set_alloc(5'd11, 1); step();
    set_disp0(5'd10, 10'h50, 32'h5A5A, 1);
    set_disp1(5'd11, 10'h51, 32'hA5A5, 1);
    step();
    mem_stall = 1'b1;
    set_commit(2); step();
    for (int c = 0; c < 3; c++) begin
      chk("stall_we", mem_we, 0);
      step();
    end
    chk("stall_hold_addr", mem_addr, 32'h50);
    chk("stall_hold_data", mem_wdata, 32'h5A5A);
    mem_stall = 1'b0;
    wait_drain(10);

    // Forwarding and load blocking
    set_alloc(5'd1, 1); step();
    set_alloc(5'd2, 1); step();
    set_disp0(5'd1, 10'h20, 32'h11, 1);
    set_disp1(5'd2, 10'h20, 32'h22, 1);
    step();
    ld_v = 1'b1; ld_addr = 10'h20; #1;
    chk("fwd_hit", fwd_hit, 1);
    chk("fwd_data_youngest", fwd_data, 32'h22);
    chk("fwd_no_block", ld_block, 0);
    ld_addr = 10'h21; #1;
    chk("fwd_miss_hit", fwd_hit, 0);
    chk("fwd_miss_data", fwd_data, 0);
    chk("fwd_miss_block", ld_block, 0);
    set_alloc(5'd3, 1); step();
    ld_addr = 10'h20; #1;
    chk("blk_hit", fwd_hit, 1);
    chk("blk_data", fwd_data, 32'h22);
    chk("blk_block", ld_block, 1);
    ld_addr = 10'h21; #1;
    chk("blk_miss_block", ld_block, 1);
    ld_v = 1'b0; #1;
    chk("ldv0_hit", fwd_hit, 0);
    chk("ldv0_data", fwd_data, 0);
    chk("ldv0_block", ld_block, 0);
    // Both ports on one tag: port 0 supplies address/data
    set_disp0(5'd3, 10'h30, 32'h33, 1);
    set_disp1(5'd3, 10'h31, 32'h99, 0);
    step();
    ld_v = 1'b1; ld_addr = 10'h31; #1;
    chk("port1_lost_hit", fwd_hit, 0);
    ld_addr = 10'h30; #1;
    chk("port0_wins_hit", fwd_hit, 1);
    chk("port0_wins_data", fwd_data, 32'h33);
    chk("port0_wins_block", ld_block, 0);
    ld_v = 1'b0;
    set_commit(2); step();
    set_commit(1); step();
    wait_drain(10);

    // Pipelined alloc/dispatch/commit with concurrent drain across wrap
    for (int c = 0; c < 22; c++) begin
      if (c < 20) set_alloc(5'((c + 12) % 32), 1);
      if (c >= 1 && c <= 20) begin
        t = 5'((c - 1 + 12) % 32);
        set_disp0(t, 10'(10'h100 + c - 1), 32'hC000_0000 + c - 1, 1);
      end
      if (c >= 2) set_commit(1);
      step();
      chk("wrap_not_full", full, 0);
    end
    wait_drain(10);

    // Reset with committed and allocated stores outstanding
    mem_stall = 1'b1;
    set_alloc(5'd5, 1); step();
    set_disp0(5'd5, 10'h77, 32'h7777, 1); step();
    set_commit(1); step();
    set_alloc(5'd6, 1); step();
    ld_v = 1'b1; ld_addr = 10'h77; #1;
    chk("pre_rst_hit", fwd_hit, 1);
    rst = 1'b0; mem_stall = 1'b0;
    exp_q.delete(); order_q.delete();
    #1;
    chk("rst_full", full, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_ld_block", ld_block, 0);
    ld_v = 1'b0;
    step();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst_mem_we", mem_we, 0);
    end
    chk("final_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
